// File: rtl/tinyriscv_pkg.sv
// Shared types for the tinyriscv core: register-file bus widths and the
// JTAG register-access FSM state encoding.
package tinyriscv_pkg;

    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned RegWidth     = 32;

    typedef logic [RegAddrWidth-1:0] RegAddrBus;
    typedef logic [RegWidth-1:0]     RegBus;
    typedef logic                    WriteEnable;

    // States of the JTAG register-access initiator
    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StResp
    } jtag_acc_state_e;

endpackage

// File: rtl/jtag_reg_access.sv
// Debug-side initiator for the register file's JTAG port. Runs one read or
// write per command, snoops the ex write port and retries any access that the
// register file would drop (write) or return stale data for (read).
module jtag_reg_access
    import tinyriscv_pkg::*;
#(
    parameter int unsigned MaxRetry = 3
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      req_valid_i,
    output logic      req_ready_o,
    input  logic      req_write_i,
    input  RegAddrBus req_addr_i,
    input  RegBus     req_wdata_i,
    output logic      rsp_valid_o,
    input  logic      rsp_ready_i,
    output RegBus     rsp_rdata_o,
    output logic      rsp_err_o,
    output logic      jtag_we_o,
    output RegAddrBus jtag_addr_o,
    output RegBus     jtag_data_o,
    input  RegBus     jtag_data_i,
    input  logic      ex_we_i,
    input  RegAddrBus ex_waddr_i,
    output logic      busy_o
);

    localparam int unsigned CntW = $clog2(MaxRetry + 1);

    jtag_acc_state_e state_q, state_d;
    RegAddrBus       addr_q, addr_d;
    RegBus           wdata_q, wdata_d;
    RegBus           rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            collision;
    logic            retry_left;

    // Writes lose to any ex write; reads are stale only if ex hits the same register
    always_comb begin
        collision = 1'b0;
        if (state_q == StWrite) begin
            collision = ex_we_i && (ex_waddr_i != '0);
        end else if (state_q == StRead) begin
            collision = ex_we_i && (ex_waddr_i == addr_q);
        end
    end

    assign retry_left = (cnt_q < CntW'(MaxRetry));

    // Next-state logic: accept, access with bounded retry, then hold response
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = '0;
                    if (req_write_i && (req_addr_i == '0)) begin
                        // x0 is read-only: fail without touching the register file
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (req_write_i) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite, StRead: begin
                if (collision) begin
                    if (retry_left) begin
                        cnt_d = cnt_q + CntW'(1);
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end else begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = (state_q == StWrite) ? wdata_q : jtag_data_i;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and command registers; reset aborts any command in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ready is masked by reset so it stays low while rst_i is held
    assign req_ready_o = (state_q == StIdle) && !rst_i;
    assign busy_o      = (state_q != StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign jtag_we_o   = (state_q == StWrite);
    assign jtag_addr_o = (state_q != StIdle) ? addr_q : '0;
    assign jtag_data_o = (state_q != StIdle) ? wdata_q : '0;

endmodule

// File: tb/tb_jtag_reg_access.sv
// Self-checking bench for jtag_reg_access with a small register-file model
// that gives ex writes priority and has no ex-to-jtag bypass.
module tb_jtag_reg_access;
    import tinyriscv_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      req_valid = 1'b0;
    logic      req_ready;
    logic      req_write = 1'b0;
    RegAddrBus req_addr = '0;
    RegBus     req_wdata = '0;
    logic      rsp_valid;
    logic      rsp_ready = 1'b1;
    RegBus     rsp_rdata;
    logic      rsp_err;
    logic      jtag_we;
    RegAddrBus jtag_addr;
    RegBus     jtag_wdata;
    RegBus     jtag_rdata;
    logic      ex_we = 1'b0;
    RegAddrBus ex_waddr = '0;
    RegBus     ex_wdata = '0;
    logic      busy;

    int checks = 0;
    int errors = 0;

    RegBus rf [32];

    always #5 clk = ~clk;

    jtag_reg_access #(.MaxRetry(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .jtag_we_o   (jtag_we),
        .jtag_addr_o (jtag_addr),
        .jtag_data_o (jtag_wdata),
        .jtag_data_i (jtag_rdata),
        .ex_we_i     (ex_we),
        .ex_waddr_i  (ex_waddr),
        .busy_o      (busy)
    );

    // Register file model: ex write wins, x0 reads as zero
    assign jtag_rdata = (jtag_addr == '0) ? '0 : rf[jtag_addr];

    always @(posedge clk) begin
        if (ex_we && ex_waddr != '0) rf[ex_waddr] <= ex_wdata;
        else if (jtag_we && jtag_addr != '0) rf[jtag_addr] <= jtag_wdata;
    end

    typedef struct {
        logic        write;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  ex_mask;   // ex_we per cycle after accept
        logic [4:0]  ex_addr;
        logic [31:0] ex_data;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;   // cycles from accept edge to first rsp_valid cycle
        int          exp_pulses;
    } vec_t;

    localparam int NumVec = 10;
    vec_t vecs [NumVec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input vec_t v, input int idx);
        int   lat;
        int   pulses;
        logic done;
        logic ready_low;
        logic pulse_ok;
        string tag;
        tag = $sformatf("vec%0d", idx);
        check({tag, " ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = 0;
        pulses    = 0;
        done      = 1'b0;
        ready_low = 1'b1;
        pulse_ok  = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            lat++;
            if (req_ready) ready_low = 1'b0;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (jtag_we) begin
                    pulses++;
                    if (jtag_addr != v.addr || jtag_wdata != v.wdata) pulse_ok = 1'b0;
                end
                ex_we    = v.ex_mask[k%8];
                ex_waddr = v.ex_addr;
                ex_wdata = v.ex_data;
                @(posedge clk);
                #1;
                ex_we = 1'b0;
            end
        end
        check({tag, " rsp_seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " pulses"}, 32'(pulses), 32'(v.exp_pulses));
        check({tag, " pulse_addr_data"}, 32'(pulse_ok), 32'd1);
        check({tag, " ready_low_busy"}, 32'(ready_low), 32'd1);
        check({tag, " err"}, 32'(rsp_err), 32'(v.exp_err));
        if (v.chk_rdata) check({tag, " rdata"}, rsp_rdata, v.exp_rdata);
        @(posedge clk);
        #1;
        check({tag, " rsp_dropped"}, 32'(rsp_valid), 32'd0);
        check({tag, " ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int   wait_cnt;
        logic seen;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        //       wr    addr  wdata          exmask  exaddr exdata  chk  exp_rdata      err lat pulses
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 8'h00, 5'd0, 32'h0,  1'b1, 32'hDEADBEEF, 1'b0, 2, 1};
        vecs[1] = '{1'b0, 5'd5, 32'h0,        8'h00, 5'd0, 32'h0,  1'b1, 32'hDEADBEEF, 1'b0, 2, 0};
        vecs[2] = '{1'b1, 5'd0, 32'h1234,     8'h00, 5'd0, 32'h0,  1'b0, 32'h0,        1'b1, 1, 0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        8'h00, 5'd0, 32'h0,  1'b1, 32'h0,        1'b0, 2, 0};
        vecs[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, 8'h03, 5'd3, 32'h33, 1'b1, 32'hA5A5A5A5, 1'b0, 4, 3};
        vecs[5] = '{1'b1, 5'd7, 32'h0BADF00D, 8'hFF, 5'd3, 32'h44, 1'b0, 32'h0,        1'b1, 5, 4};
        vecs[6] = '{1'b0, 5'd9, 32'h0,        8'h01, 5'd9, 32'h55, 1'b1, 32'h55,       1'b0, 3, 0};
        vecs[7] = '{1'b0, 5'd5, 32'h0,        8'h01, 5'd3, 32'h66, 1'b1, 32'hDEADBEEF, 1'b0, 2, 0};
        vecs[8] = '{1'b1, 5'd6, 32'h600DCAFE, 8'h01, 5'd0, 32'h77, 1'b1, 32'h600DCAFE, 1'b0, 2, 1};
        vecs[9] = '{1'b0, 5'd7, 32'h0,        8'h00, 5'd0, 32'h0,  1'b1, 32'hA5A5A5A5, 1'b0, 2, 0};

        // Reset state
        #2;
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst jtag_we", 32'(jtag_we), 32'd0);
        check("rst jtag_addr", 32'(jtag_addr), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst ready", 32'(req_ready), 32'd1);
        check("idle jtag_data", jtag_wdata, 32'd0);

        for (int i = 0; i < NumVec; i++) do_cmd(vecs[i], i);

        // Response backpressure: rsp_* held and no new accept for 5 cycles
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 1'b0;
        wait_cnt = 0;
        while (!seen && wait_cnt < 10) begin
            if (rsp_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                wait_cnt++;
            end
        end
        check("bp rsp_seen", 32'(seen), 32'd1);
        req_valid = 1'b1;  // a pending request must not be accepted meanwhile
        req_write = 1'b1;
        req_addr  = 5'd5;
        req_wdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp err", 32'(rsp_err), 32'd0);
            check("bp ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp released", 32'(rsp_valid), 32'd0);
        check("bp ready_after", 32'(req_ready), 32'd1);
        check("bp no_write", rf[5], 32'hDEADBEEF);

        // Reset during a write retry
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 5'd7;
        req_wdata = 32'hFFFF0000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ex_we     = 1'b1;
        ex_waddr  = 5'd3;
        ex_wdata  = 32'h88;
        @(posedge clk);
        #1;
        check("rr retry pulse", 32'(jtag_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rr jtag_we", 32'(jtag_we), 32'd0);
        check("rr busy", 32'(busy), 32'd0);
        check("rr ready", 32'(req_ready), 32'd0);
        check("rr rsp_valid", 32'(rsp_valid), 32'd0);
        ex_we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("rr no_rsp", 32'(seen), 32'd0);
        check("rr idle", 32'(busy), 32'd0);
        check("rr ready_after", 32'(req_ready), 32'd1);
        check("rr x7_kept", rf[7], 32'hA5A5A5A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
